// File: rtl/tile_buffer_file.sv
// tile_buffer_file: array of tile buffers with auto-incrementing write/read tile pointers.
// A change of buffer id restarts that port at tile 0; reads are registered one cycle later.
module tile_buffer_file #(
  parameter int BUFFER_WIDTH = 8192,
  parameter int BUFFER_COUNT = 32,
  parameter int TILE_WIDTH   = 256,
  parameter int DATA_WIDTH   = 8,
  parameter int TILE_SIZE    = TILE_WIDTH / DATA_WIDTH,
  localparam int TILES_PER_BUFFER = BUFFER_WIDTH / TILE_WIDTH,
  localparam int ID_W = $clog2(BUFFER_COUNT)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         write_enable,
  input  logic [TILE_WIDTH-1:0]        write_data,
  input  logic [ID_W-1:0]              write_buffer,
  input  logic                         read_enable,
  input  logic [ID_W-1:0]              read_buffer,
  output logic signed [DATA_WIDTH-1:0] read_data [TILE_SIZE],
  output logic                         writing_done,
  output logic                         reading_done
);
  localparam int PW = TILES_PER_BUFFER > 1 ? $clog2(TILES_PER_BUFFER) : 1;
  localparam logic [ID_W:0] BC = (ID_W+1)'(BUFFER_COUNT);
  localparam logic [PW-1:0] LAST = PW'(TILES_PER_BUFFER - 1);

  logic [TILE_WIDTH-1:0] mem [BUFFER_COUNT][TILES_PER_BUFFER];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, widx, ridx;
  logic [ID_W-1:0] last_wid_q, last_rid_q;
  logic wvalid, rvalid, wlast, writing_done_q, reading_done_q;
  logic [TILE_WIDTH-1:0] rtile;
  logic signed [DATA_WIDTH-1:0] read_data_q [TILE_SIZE];

  always_comb begin
    wvalid = write_enable && ({1'b0, write_buffer} < BC);
    rvalid = {1'b0, read_buffer} < BC;
    widx   = (write_buffer != last_wid_q) ? '0 : wptr_q;
    ridx   = (read_buffer != last_rid_q) ? '0 : rptr_q;
    wlast  = widx == LAST;
    wptr_d = wlast ? '0 : widx + PW'(1);
    rptr_d = (ridx == LAST) ? '0 : ridx + PW'(1);
    rtile  = rvalid ? mem[read_buffer][ridx] : '0;
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk)
    if (wvalid) mem[write_buffer][widx] <= write_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q         <= '0;
      rptr_q         <= '0;
      last_wid_q     <= '0;
      last_rid_q     <= '0;
      writing_done_q <= 1'b0;
      reading_done_q <= 1'b0;
      for (int i = 0; i < TILE_SIZE; i++) read_data_q[i] <= '0;
    end else begin
      writing_done_q <= wvalid && wlast;
      reading_done_q <= read_enable;
      if (wvalid) begin
        wptr_q     <= wptr_d;
        last_wid_q <= write_buffer;
      end
      if (read_enable) begin
        rptr_q     <= rptr_d;
        last_rid_q <= read_buffer;
        for (int i = 0; i < TILE_SIZE; i++) read_data_q[i] <= rtile[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign read_data    = read_data_q;
  assign writing_done = writing_done_q;
  assign reading_done = reading_done_q;
endmodule

// File: tb/tb_tile_buffer_file.sv
// tb_tile_buffer_file: random and directed stimulus checked every cycle against a
// behavioural model of the tile buffers, plus literal expectations for known scenarios.
module tb_tile_buffer_file;
  localparam int TW = 32, DW = 8, TS = 4, BW = 128, BC = 4, TPB = BW / TW;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic write_enable = 1'b0, read_enable = 1'b0;
  logic [TW-1:0] write_data = '0;
  logic [1:0] write_buffer = '0, read_buffer = '0;
  logic signed [DW-1:0] read_data [TS];
  logic writing_done, reading_done;

  int checks = 0, errors = 0;
  bit chk_en = 0;

  tile_buffer_file #(.BUFFER_WIDTH(BW), .BUFFER_COUNT(BC), .TILE_WIDTH(TW),
                     .DATA_WIDTH(DW), .TILE_SIZE(TS)) dut (
    .clk(clk), .reset_n(reset_n),
    .write_enable(write_enable), .write_data(write_data), .write_buffer(write_buffer),
    .read_enable(read_enable), .read_buffer(read_buffer),
    .read_data(read_data), .writing_done(writing_done), .reading_done(reading_done));

  always #5 clk = ~clk;

  logic [TW-1:0] mm [BC][TPB];
  int wp, lw, rp, lr, mi;
  logic [TW-1:0] exp_t;
  bit exp_wd, exp_rd;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp = 0; lw = 0; rp = 0; lr = 0; exp_t = '0; exp_wd = 0; exp_rd = 0;
    end else begin
      exp_rd = read_enable;
      exp_wd = 0;
      if (read_enable) begin
        mi = (int'(read_buffer) == lr) ? rp : 0;
        exp_t = (int'(read_buffer) < BC) ? mm[read_buffer][mi] : '0;
        rp = (mi + 1) % TPB;
        lr = int'(read_buffer);
      end
      if (write_enable && int'(write_buffer) < BC) begin
        mi = (int'(write_buffer) == lw) ? wp : 0;
        mm[write_buffer][mi] = write_data;
        exp_wd = (mi == TPB - 1);
        wp = (mi + 1) % TPB;
        lw = int'(write_buffer);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (reading_done !== exp_rd) begin
        errors++;
        $display("FAIL reading_done @%0t: got %b expected %b", $time, reading_done, exp_rd);
      end
      checks++;
      if (writing_done !== exp_wd) begin
        errors++;
        $display("FAIL writing_done @%0t: got %b expected %b", $time, writing_done, exp_wd);
      end
      for (int i = 0; i < TS; i++) begin
        checks++;
        if (read_data[i] !== $signed(exp_t[i*DW +: DW])) begin
          errors++;
          $display("FAIL read_data[%0d] @%0t: got %0d expected %0d", i, $time, read_data[i], $signed(exp_t[i*DW +: DW]));
        end
      end
    end
  end

  task automatic cyc(input logic we, input logic [TW-1:0] wd, input logic [1:0] wb,
                     input logic re, input logic [1:0] rb);
    write_enable = we; write_data = wd; write_buffer = wb;
    read_enable = re; read_buffer = rb;
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic got, input logic expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, got, expv);
    end
  endtask

  task automatic lit(input string nm, input int e0, input int e1, input int e2, input int e3);
    int e [TS];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < TS; i++) begin
      checks++;
      if (int'(read_data[i]) != e[i]) begin
        errors++;
        $display("FAIL %s[%0d]: got %0d expected %0d", nm, i, read_data[i], e[i]);
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [1:0] wb_r, rb_r;
    #2 reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk_en = 1;
    lit("reset_data", 0, 0, 0, 0);
    chk("reset_rdone", reading_done, 1'b0);
    for (int b = 0; b < BC; b++)
      for (int t = 0; t < TPB; t++) cyc(1'b1, $urandom, 2'(b), 1'b0, 2'd0);
    cyc(1'b0, '0, 2'd0, 1'b0, 2'd0);
    do_reset();

    cyc(1'b1, 32'h04030201, 2'd2, 1'b0, 2'd0);
    cyc(1'b1, 32'h08070605, 2'd2, 1'b0, 2'd0);
    cyc(1'b0, '0, 2'd0, 1'b1, 2'd2);
    lit("r22_first", 1, 2, 3, 4);
    chk("r22_done_a", reading_done, 1'b1);
    cyc(1'b0, '0, 2'd0, 1'b1, 2'd2);
    lit("r22_second", 5, 6, 7, 8);
    chk("r22_done_b", reading_done, 1'b1);
    cyc(1'b0, '0, 2'd0, 1'b0, 2'd0);
    chk("r22_idle", reading_done, 1'b0);

    for (int k = 0; k < TPB; k++) begin
      cyc(1'b1, 32'h11110000 + k, 2'd1, 1'b0, 2'd0);
      chk($sformatf("r23_wdone_%0d", k), writing_done, k == TPB - 1);
    end
    cyc(1'b1, 32'h55555555, 2'd1, 1'b0, 2'd0);
    chk("r23_wdone_5th", writing_done, 1'b0);
    cyc(1'b0, '0, 2'd0, 1'b1, 2'd1);
    lit("r23_wrap", 85, 85, 85, 85);

    cyc(1'b1, 32'hFF80017F, 2'd3, 1'b0, 2'd0);
    cyc(1'b0, '0, 2'd0, 1'b1, 2'd3);
    lit("r24_signed", 127, 1, -128, -1);

    cyc(1'b1, 32'hA0A1A2A3, 2'd0, 1'b0, 2'd0);
    cyc(1'b1, 32'hB0B1B2B3, 2'd1, 1'b0, 2'd0);
    cyc(1'b1, 32'hC0C1C2C3, 2'd0, 1'b0, 2'd0);
    cyc(1'b0, '0, 2'd0, 1'b1, 2'd0);
    lit("r25_restart", -61, -62, -63, -64);

    cyc(1'b1, 32'h12345678, 2'd1, 1'b1, 2'd1);
    cyc(1'b1, 32'h7F7E7D7C, 2'd0, 1'b1, 2'd0);
    lit("r26_old", -61, -62, -63, -64);
    cyc(1'b0, '0, 2'd0, 1'b1, 2'd1);
    cyc(1'b0, '0, 2'd0, 1'b1, 2'd0);
    lit("r26_new", 124, 125, 126, 127);

    wb_r = 2'd0; rb_r = 2'd0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) wb_r = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) rb_r = 2'($urandom_range(0, 3));
      cyc(1'($urandom_range(0, 1)), $urandom, wb_r, 1'($urandom_range(0, 1)), rb_r);
    end

    cyc(1'b0, '0, 2'd0, 1'b1, 2'd0);
    cyc(1'b0, '0, 2'd0, 1'b1, 2'd0);
    @(posedge clk);
    #2;
    chk("r27_pre_rdone", reading_done, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("r27_async_rdone", reading_done, 1'b0);
    lit("r27_async_data", 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1'b0, '0, 2'd0, 1'b1, 2'd0);
    chk("r27_read_done", reading_done, 1'b1);
    for (int i = 0; i < TS; i++) begin
      checks++;
      if (read_data[i] !== $signed(mm[0][0][i*DW +: DW])) begin
        errors++;
        $display("FAIL r27_tile0[%0d]: got %0d expected %0d", i, read_data[i], $signed(mm[0][0][i*DW +: DW]));
      end
    end
    cyc(1'b0, '0, 2'd0, 1'b0, 2'd0);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
